// File: rtl/seq_gen.sv
// Serial bit-sequence generator: shifts a loaded pattern out LSB-first (optionally repeated)
// or emits a 16-bit Fibonacci LFSR stream seeded from the load word.
module seq_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             mode,
    input  logic [3:0]       reps,
    input  logic             abort,
    output logic             outp,
    output logic             out_valid,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] pat_q;
    logic [BW-1:0]    bcnt_q;
    logic [3:0]       rcnt_q;
    logic             mode_q;

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] seed_d;
    logic             mode_d;

    // The LFSR taps only exist for the 16-bit case; other widths are pattern-only.
    generate
        if (WIDTH == 16) begin : g_lfsr
            logic fb;
            assign fb      = sr_q[0] ^ sr_q[2] ^ sr_q[3] ^ sr_q[5];
            assign shift_d = mode_q ? {fb, sr_q[WIDTH-1:1]} : {1'b0, sr_q[WIDTH-1:1]};
            assign seed_d  = (mode && (data == '0)) ? 16'hACE1 : data;
            assign mode_d  = mode;
        end else begin : g_plain
            assign shift_d = {1'b0, sr_q[WIDTH-1:1]};
            assign seed_d  = data;
            assign mode_d  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            pat_q   <= '0;
            bcnt_q  <= '0;
            rcnt_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        sr_q    <= seed_d;
                        pat_q   <= data;
                        rcnt_q  <= reps;
                        bcnt_q  <= '0;
                        mode_q  <= mode_d;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (bcnt_q == LAST_BIT) begin
                        if (rcnt_q != 4'd0) begin
                            // Next block starts immediately; the LFSR keeps running across blocks.
                            rcnt_q <= rcnt_q - 4'd1;
                            bcnt_q <= '0;
                            sr_q   <= mode_q ? shift_d : pat_q;
                        end else begin
                            sr_q    <= shift_d;
                            state_q <= S_DONE;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                        sr_q   <= shift_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign outp      = (state_q == S_SHIFT) && sr_q[0];
    assign out_valid = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT);
    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: stimulus pushes expected serial bits, a negedge monitor pops and checks.
module tb_seq_gen;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic        mode;
    logic [3:0]  reps;
    logic        abort;
    logic        outp;
    logic        out_valid;
    logic        ready;
    logic        busy;
    logic        done;

    seq_gen #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      (data),
        .mode      (mode),
        .reps      (reps),
        .abort     (abort),
        .outp      (outp),
        .out_valid (out_valid),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind on the last expected bit: 0 more bits follow, 1 completes with done, 2 aborted, 3 reset
    typedef struct {
        logic b;
        int   kind;
    } rec_t;

    rec_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   pend_kind = 0;
    int   pend_step = 0;
    bit   mon_en = 0;
    int   bit_no = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference stream built directly from the generator's rules.
    function automatic void model(input logic [15:0] d, input logic m, input logic [3:0] r,
                                  output logic q[$]);
        logic [15:0] s;
        logic        fb;
        q = {};
        s = (m && d == 16'h0) ? 16'hACE1 : d;
        for (int rep = 0; rep <= int'(r); rep++) begin
            for (int i = 0; i < 16; i++) begin
                if (m) begin
                    q.push_back(s[0]);
                    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
                    s  = {fb, s[15:1]};
                end else begin
                    q.push_back(d[i]);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (pend_kind == 1) begin
                if (pend_step == 0) begin
                    chk("done_pulse", {13'b0, done, out_valid, ready}, 16'b100);
                    pend_step = 1;
                end else begin
                    chk("ready_after_done", {14'b0, done, ready}, 16'b01);
                    pend_kind = 0;
                end
            end else if (pend_kind == 2) begin
                chk("after_abort", {13'b0, out_valid, ready, done}, 16'b010);
                pend_kind = 0;
            end else if (pend_kind == 3) begin
                chk("after_rst", {11'b0, outp, out_valid, ready, busy, done}, 16'b00100);
                pend_kind = 0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 16'd1, 16'd0);
                end else begin
                    rec_t e;
                    e = sb.pop_front();
                    chk($sformatf("bit%0d", bit_no), {15'b0, outp}, {15'b0, e.b});
                    chk("busy_ready", {14'b0, busy, ready}, 16'b10);
                    bit_no++;
                    if (e.kind != 0) begin
                        pend_kind = e.kind;
                        pend_step = 0;
                        bit_no = 0;
                    end
                end
            end else if (done) begin
                chk("unexpected_done", 16'd1, 16'd0);
            end
        end
    end

    // stop_at < 0: full stream; otherwise bit index during which abort (kind 2) or rst (kind 3) is raised
    task automatic run(input logic [15:0] d, input logic m, input logic [3:0] r,
                       input int stop_at, input int stop_kind,
                       input bit stray_load, input bit abort_with_load);
        logic q[$];
        int   nb;
        int   t;
        t = 0;
        while (!ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_ready", {15'b0, ready}, 16'd1);
        model(d, m, r, q);
        nb = (stop_at < 0) ? q.size() : stop_at + 1;
        for (int i = 0; i < nb; i++) begin
            rec_t e;
            e.b    = q[i];
            e.kind = (i == nb - 1) ? ((stop_at < 0) ? 1 : stop_kind) : 0;
            sb.push_back(e);
        end
        $display("[TB] load data=%04h mode=%0d reps=%0d bits=%0d stop=%0d", d, m, r, nb, stop_kind);
        load  = 1'b1;
        data  = d;
        mode  = m;
        reps  = r;
        abort = abort_with_load;
        @(posedge clk); #1;
        load  = 1'b0;
        abort = 1'b0;
        data  = 16'($urandom);
        mode  = 1'($urandom);
        reps  = 4'($urandom);
        if (stop_at >= 0) begin
            for (int k = 0; k < stop_at; k++) begin
                if (stray_load && k == 2) load = 1'b1;
                @(posedge clk); #1;
                load = 1'b0;
            end
            if (stop_kind == 2) abort = 1'b1;
            else rst = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            rst   = 1'b0;
        end
        t = 0;
        while ((sb.size() != 0 || pend_kind != 0) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("stream_drained", 16'(sb.size()), 16'd0);
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        data  = 16'h0;
        mode  = 1'b0;
        reps  = 4'd0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_outp", {15'b0, outp}, 16'd0);
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_ready", {15'b0, ready}, 16'd1);
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_done", {15'b0, done}, 16'd0);
        mon_en = 1'b1;

        run(16'h5772, 1'b0, 4'd0, -1, 0, 1'b0, 1'b0);
        run(16'h0003, 1'b0, 4'd2, -1, 0, 1'b0, 1'b0);
        run(16'hACE1, 1'b1, 4'd0, -1, 0, 1'b0, 1'b0);
        run(16'h0000, 1'b1, 4'd0, -1, 0, 1'b0, 1'b0);
        run(16'h5772, 1'b0, 4'd1,  5, 2, 1'b1, 1'b0);
        run(16'h5772, 1'b0, 4'd0,  9, 3, 1'b0, 1'b0);
        run(16'h5772, 1'b0, 4'd0, -1, 0, 1'b0, 1'b0);
        run(16'h9BD3, 1'b1, 4'd1, -1, 0, 1'b0, 1'b1);

        // abort while idle must be ignored
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 abort = 1'b0;
        chk("idle_abort_ready", {15'b0, ready}, 16'd1);

        for (int n = 0; n < 24; n++) begin
            logic [15:0] d;
            logic        m;
            logic [3:0]  r;
            int          sel;
            int          sa;
            d   = 16'($urandom);
            m   = 1'($urandom);
            r   = 4'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            sa  = $urandom_range(0, 16 * (int'(r) + 1) - 1);
            if (sel == 0)      run(d, m, r, sa, 2, 1'b1, 1'b0);
            else if (sel == 1) run(d, m, r, sa, 3, 1'b0, 1'b0);
            else               run(d, m, r, -1, 0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", {14'b0, ready, out_valid}, 16'b10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-sequence generator: the transmitting end for the `fsm` Mealy sequence detector. It drives one bit per clock onto the detector's `inp` line. It either shifts a loaded pattern out LSB-first, optionally repeated, or emits a 16-bit LFSR pseudo-random stream seeded from the load word. It replaces hand-coded stimulus loops, so detector stimulus is produced in-circuit and is reproducible.

## Interface
- `WIDTH`, 16: pattern length in bits; LFSR mode is only supported when WIDTH == 16.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load`  in  1  start request; accepted only when `ready` = 1.
- `data`  in  WIDTH  pattern (mode 0) or LFSR seed (mode 1); sampled with `load`.
- `mode`  in  1  0 = pattern shift, 1 = LFSR; sampled with `load`; forced to 0 when WIDTH != 16.
- `reps`  in  4  extra repetitions (0..15); sampled with `load`.
- `abort`  in  1  terminates the stream early.
- `outp`  out  1  serial bit; drive to detector `inp`.
- `out_valid`  out  1  `outp` carries a stream bit this cycle.
- `ready`  out  1  idle, `load` will be accepted.
- `busy`  out  1  stream in progress.
- `done`  out  1  one-cycle pulse after the final bit of a completed (non-aborted) stream.

## Operation
- States:
  - IDLE (`ready` = 1).
  - SHIFT (`busy` = 1, `out_valid` = 1).
  - DONE (`done` = 1, one cycle).
- Registers:
  - Shift register `sr[WIDTH-1:0]`.
  - Saved pattern `pat`.
  - Bit counter `bcnt`, width $clog2(WIDTH).
  - Repetition counter `rcnt[3:0]`.
  - Latched `mode_q`.
- Accepting a load (IDLE with `load` = 1):
  - `sr` <= `data` and `pat` <= `data`.
  - `rcnt` <= `reps`, `bcnt` <= 0, `mode_q` <= `mode`.
  - Go to SHIFT.
- Mode 1 with `data` == 0: the seed is replaced by 16'hACE1, so the all-zero lock-up state is never used.
- `outp` = `sr[0]` while in SHIFT; `outp` = 0 in every other state.
- Per SHIFT cycle in mode 0: `sr` <= {1'b0, `sr`[WIDTH-1:1]}.
- Per SHIFT cycle in mode 1:
  - `fb` = `sr[0]` ^ `sr[2]` ^ `sr[3]` ^ `sr[5]`.
  - `sr` <= {`fb`, `sr[15:1]`} (polynomial x^16+x^14+x^13+x^11+1).
- End of a block (`bcnt` == WIDTH-1):
  - If `rcnt` != 0: `rcnt` decrements and `bcnt` <= 0. In mode 0, `sr` <= `pat`; in mode 1 the LFSR continues. Stay in SHIFT with no gap cycle.
  - If `rcnt` == 0: go to DONE. DONE always goes to IDLE on the next edge.
  - Otherwise `bcnt` increments.
- `abort`:
  - In SHIFT: go to IDLE on the next edge; no DONE and no `done` pulse.
  - In IDLE or DONE: ignored.
- `load` while not `ready`: ignored, and nothing is queued.
- `load` and `abort` together in IDLE: the load wins.

## Timing
- Reset values: state = IDLE, `outp` = 0, `out_valid` = 0, `ready` = 1, `busy` = 0, `done` = 0. All registers are cleared.
- `rst` has priority over every other input, in every state and mid-stream. It takes effect on the next edge.
- Load sampled at edge N: bit k (0-based) is valid in the cycle after edge N+k.
- Total valid bits per stream = WIDTH * (`reps` + 1), contiguous, with `out_valid` never dropping.
- `done` is high in the cycle after the last valid bit. `ready` returns the cycle after that.
- Minimum load-to-load spacing = WIDTH * (`reps` + 1) + 2 cycles.
- Abort sampled at edge M: the cycle after edge M has `out_valid` = 0 and `ready` = 1.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then load `data` = 16'h5772, `mode` = 0, `reps` = 0:
  - `outp` sequence is 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0.
  - `out_valid` is high for exactly 16 cycles, then `done` pulses once, then `ready` = 1.
- Load 16'h0003, `reps` = 2:
  - 48 contiguous valid bits in the pattern 1,1,0×14, repeated three times.
  - There is no gap between blocks.
- Mode 1, seed 16'hACE1, `reps` = 0:
  - First outputs are 1, 0.
  - `sr` after the first shift is 16'h5670.
  - The stream matches a software LFSR model for all 16 bits.
- Mode 1, seed 16'h0000: the stream is identical to the seed 16'hACE1 case.
- Assert `abort` on bit 5:
  - The next cycle has `out_valid` = 0 and `ready` = 1, with no `done`.
  - A `load` asserted during the stream was ignored.
- Assert `rst` mid-stream at bit 9:
  - All outputs take their reset values on the next edge.
  - A following load of 16'h5772 reproduces the first scenario.
  - Drive `outp` into `fsm`; the detector output matches its reference model.
